ads5296_tx_emulator: RTL
========================

Name: ads5296_tx_emulator

Overview:
- Transmit-side counterpart of the ADS5296 demux-2 receiver. It generates 2-wire-per-channel, 10-bit DDR ADC lane traffic plus a frame-clock pattern, so the receiver chain can be tested in loopback or simulation without a physical ADC.
- Outputs are 5-bit parallel slices per wire per sclk2_in cycle, one 10-bit sample per channel per cycle. They feed external 5:1 DDR serializers running on the sclk5 bit clock.
- Provides test patterns and a user stream FIFO, a sync-triggered alignment sequence, and a programmable bit-slip so the receiver's bitslip logic can be exercised.

Parameters:
- G_NUM_CH, 16: number of ADC channels (4 chips x 4 channels).
- G_FIFO_ADDR_BITS, 4: log2 depth of the user-sample FIFO.
- G_ALIGN_FRAMES, 16: number of sclk2_in cycles of alignment pattern emitted after sync.

Ports:
- sclk2_in, in, 1: interleaved sample clock; the only clock.
- rst, in, 1: synchronous, active-high reset.
- mode, in, 2: pattern select. 0 = const, 1 = ramp, 2 = LFSR, 3 = user stream.
- const_val, in, 10: constant-pattern value; also the underflow filler.
- slip, in, 3: bit-time delay applied to every wire, 0..4. Values 5..7 are treated as 4.
- sync_in, in, 1: level input; a rising edge starts the alignment sequence.
- s_data, in, 10*G_NUM_CH: user samples, channel k at [10k+9:10k].
- s_valid, in, 1: user-stream valid.
- s_ready, out, 1: user-stream ready; equals FIFO not full.
- dout_a, out, 5*G_NUM_CH: wire-A slices. Channel k at [5k+4:5k]; bit 4 is transmitted first.
- dout_b, out, 5*G_NUM_CH: wire-B slices, same layout.
- fclk_word, out, 5: frame-clock pattern slice.
- sync_out, out, 1: pulses one cycle when the first post-alignment sample reaches dout.
- aligning, out, 1: high while the alignment pattern is on dout.
- underflow_cnt, out, 16: saturating count of mode-3 cycles with an empty FIFO.

Behaviour:
- Reset (rst=1 at a clock edge):
  - dout_a, dout_b, fclk_word, sync_out, aligning, s_ready and underflow_cnt are 0.
  - FIFO is emptied, ramp counters are 0, LFSR is 10'h001, frame phase is 0, slip history is 0.
  - s_ready rises the first cycle after rst deasserts.
  - A reset mid-sequence aborts the alignment sequence with no sync_out pulse.
- FIFO handshake:
  - A push occurs when s_valid && s_ready.
  - A pop occurs each cycle that mode==3, the FIFO is non-empty and the block is not aligning.
  - A simultaneous push and pop at full is legal: s_ready is 0, so no push happens.
  - At empty, a push and a pop in the same cycle do not bypass; the pop sees empty.
- Stage 1, generation (registered; sample index n):
  - mode 0: const_val.
  - mode 1: (ramp + k) mod 1024 for channel k. ramp increments each cycle and wraps 1023 -> 0.
  - mode 2: 10-bit LFSR, x^10+x^7+1, advanced once per cycle; all channels carry the same value.
  - mode 3: FIFO head, or const_val on empty with underflow_cnt += 1, saturating at 16'hFFFF.
  - A mode change takes effect on the next cycle's sample.
  - Generators for non-selected modes keep running.
- Alignment:
  - A rising edge of sync_in (edge-detected with one register) loads an align counter with G_ALIGN_FRAMES.
  - While the counter is nonzero, stage 1 emits 10'h3E0 on every channel, the FIFO does not pop, and the counter decrements.
  - The frame phase is forced to 0 at the load.
  - A new sync edge during alignment reloads the counter.
  - sync_out pulses on the cycle the first non-align sample appears on dout.
- Stage 2, serialization and slip (registered):
  - Sample s maps to wire A as {s9,s7,s5,s3,s1} and to wire B as {s8,s6,s4,s2,s0}.
  - Each wire keeps its previous 5-bit slice p.
  - Output = ({p,cur} >> slip)[4:0], so slip=0 gives cur and slip=1 gives {p0,cur[4:1]}.
  - A slip change applies to the next output cycle.
- Frame clock: fclk_word is 5'b11111 on phase 0 and 5'b00000 on phase 1. The phase toggles each cycle and is aligned to the same pipeline stage as data.
- Latency: a sample generated or popped at cycle n appears on dout at cycle n+2, and aligning has the same latency.

Optional Feature:
- Macro: ADS5296_TX_ERR_INJECT_EN.
- When defined, the block adds an input err_inject (1 bit). Each rising edge inverts bit 0 of channel 0's stage-1 sample for exactly one cycle; the error appears on the dout_b[0] LSB two cycles later.
- When undefined, the port is absent and no injection logic exists.

Test Plan:
- Reset, then mode=0, const_val=10'h2AA, slip=0 -> from cycle 2: every dout_a slice = 5'b11111, dout_b = 5'b00000; fclk_word alternates 11111/00000.
- mode=1 -> channel 3 on successive cycles decodes to 3, 4, 5, ...; channel 0 wraps 1023 -> 0 without glitch.
- mode=3: push 20 words with depth 16 -> s_ready drops after 16. After the FIFO drains, output = const_val and underflow_cnt increments once per empty cycle.
- sync_in rising edge with G_ALIGN_FRAMES=16 -> aligning high 16 cycles, all channels 10'h3E0; sync_out pulses once on the next cycle; fclk_word = 11111 on that cycle.
- mode=0, const_val=10'h3FF then 10'h000, slip=2 -> transition slice = 5'b11000, with 2-bit-time delay verified on both wires; slip=7 behaves as 4.
- rst asserted mid-alignment -> all outputs 0 next cycle; no sync_out pulse; FIFO empty.

Source files
------------

// File: rtl/ads5296_tx_emulator_if.sv
// ----------------------------------------------------------------------------
// ads5296_tx_emulator_if
// User-sample stream into the ADS5296 transmit emulator.
//   s_data  : G_NUM_CH packed 10-bit samples, channel k at [10k+9:10k]
//   s_valid : producer has a sample vector on s_data
//   s_ready : emulator FIFO can accept (not full)
// Modports: master = sample producer, slave = emulator.
// ----------------------------------------------------------------------------
interface ads5296_tx_emulator_if #(
    parameter int G_NUM_CH = 16
);
    logic [10*G_NUM_CH-1:0] s_data;
    logic                   s_valid;
    logic                   s_ready;

    modport master (output s_data, output s_valid, input  s_ready);
    modport slave  (input  s_data, input  s_valid, output s_ready);
endinterface

// File: rtl/ads5296_tx_emulator.sv
// ----------------------------------------------------------------------------
// ads5296_tx_emulator
// Transmit-side emulator of an ADS5296 in 2-wire, 10-bit DDR mode. Produces
// 5-bit per-wire slices every sclk2_in cycle for external 5:1 serializers,
// plus a frame-clock slice, a sync-triggered alignment sequence and a
// programmable bit-slip.
//
// Ports:
//   sclk2_in      : the only clock
//   rst           : synchronous, active-high reset
//   mode          : 0 const, 1 ramp, 2 LFSR, 3 user stream (FIFO)
//   const_val     : constant pattern / FIFO-underflow filler
//   slip          : bit-time delay 0..4 on every wire (5..7 act as 4)
//   sync_in       : rising edge starts the alignment sequence
//   s_if          : user sample stream (slave side)
//   dout_a/dout_b : wire slices, channel k at [5k+4:5k], bit 4 sent first
//   fclk_word     : frame-clock slice (11111 on phase 0, 00000 on phase 1)
//   sync_out      : one-cycle pulse with the first post-alignment sample
//   aligning      : alignment pattern currently on dout
//   underflow_cnt : saturating count of mode-3 cycles with an empty FIFO
//
// Optional build macro ADS5296_TX_ERR_INJECT_EN adds input err_inject: each
// rising edge flips bit 0 of channel 0 in stage 1 for one sample.
// ----------------------------------------------------------------------------
module ads5296_tx_emulator #(
    parameter int G_NUM_CH         = 16,
    parameter int G_FIFO_ADDR_BITS = 4,
    parameter int G_ALIGN_FRAMES   = 16
) (
    input  logic                   sclk2_in,
    input  logic                   rst,
    input  logic [1:0]             mode,
    input  logic [9:0]             const_val,
    input  logic [2:0]             slip,
    input  logic                   sync_in,
`ifdef ADS5296_TX_ERR_INJECT_EN
    input  logic                   err_inject,
`endif
    ads5296_tx_emulator_if.slave   s_if,
    output logic [5*G_NUM_CH-1:0]  dout_a,
    output logic [5*G_NUM_CH-1:0]  dout_b,
    output logic [4:0]             fclk_word,
    output logic                   sync_out,
    output logic                   aligning,
    output logic [15:0]            underflow_cnt
);
    localparam int         W     = 10 * G_NUM_CH;
    localparam int         DEPTH = 1 << G_FIFO_ADDR_BITS;
    localparam int         AB    = G_FIFO_ADDR_BITS;
    localparam int         ACW   = $clog2(G_ALIGN_FRAMES + 1);
    localparam logic [9:0] ALIGN_WORD = 10'h3E0;

    typedef enum logic [1:0] {
        MODE_CONST = 2'd0,
        MODE_RAMP  = 2'd1,
        MODE_LFSR  = 2'd2,
        MODE_USER  = 2'd3
    } mode_e;

    mode_e              mode_sel;
    logic [W-1:0]       mem [DEPTH];
    logic [AB:0]        wr_ptr, rd_ptr;
    logic               fifo_empty, fifo_full, ready_en, push, pop;
    logic [W-1:0]       fifo_head;
    logic [9:0]         ramp, lfsr;
    logic               phase, sync_q, sync_rise;
    logic [ACW-1:0]     align_cnt;
    logic               align_active, underflow_evt;
    logic [W-1:0]       gen;
    logic [W-1:0]       s1_data;
    logic               s1_phase, s1_align;
    logic [5*G_NUM_CH-1:0] cur_a, cur_b, prev_a, prev_b, nxt_a, nxt_b;
    logic [2:0]         slip_eff;
`ifdef ADS5296_TX_ERR_INJECT_EN
    logic               err_q;
`endif

    assign mode_sel      = mode_e'(mode);
    assign fifo_empty    = (wr_ptr == rd_ptr);
    assign fifo_full     = (wr_ptr[AB] != rd_ptr[AB]) && (wr_ptr[AB-1:0] == rd_ptr[AB-1:0]);
    // ready_en holds s_ready low through reset and for the reset cycle itself
    assign s_if.s_ready  = ready_en & ~fifo_full;
    assign push          = s_if.s_valid & s_if.s_ready;
    assign align_active  = (align_cnt != '0);
    assign pop           = (mode_sel == MODE_USER) & ~fifo_empty & ~align_active;
    assign underflow_evt = (mode_sel == MODE_USER) & fifo_empty & ~align_active;
    assign fifo_head     = mem[rd_ptr[AB-1:0]];
    assign sync_rise     = sync_in & ~sync_q;
    assign slip_eff      = (slip > 3'd4) ? 3'd4 : slip;

    // Stage-1 sample selection
    always_comb begin
        gen = '0;
        for (int unsigned k = 0; k < G_NUM_CH; k++) begin
            case (mode_sel)
                MODE_CONST: gen[10*k +: 10] = const_val;
                MODE_RAMP:  gen[10*k +: 10] = ramp + 10'(k);
                MODE_LFSR:  gen[10*k +: 10] = lfsr;
                MODE_USER:  gen[10*k +: 10] = fifo_empty ? const_val : fifo_head[10*k +: 10];
                default:    gen[10*k +: 10] = const_val;
            endcase
        end
        if (align_active)
            gen = {G_NUM_CH{ALIGN_WORD}};
`ifdef ADS5296_TX_ERR_INJECT_EN
        if (err_inject && !err_q)
            gen[0] = ~gen[0];
`endif
    end

    // FIFO storage: no reset needed, pointers define contents
    always_ff @(posedge sclk2_in) begin
        if (push)
            mem[wr_ptr[AB-1:0]] <= s_if.s_data;
    end

    // Generators, FIFO pointers, alignment control and stage-1 register
    always_ff @(posedge sclk2_in) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            ready_en      <= 1'b0;
            ramp          <= '0;
            lfsr          <= 10'h001;
            phase         <= 1'b0;
            sync_q        <= 1'b0;
            align_cnt     <= '0;
            underflow_cnt <= '0;
            s1_data       <= '0;
            s1_phase      <= 1'b0;
            s1_align      <= 1'b0;
`ifdef ADS5296_TX_ERR_INJECT_EN
            err_q         <= 1'b0;
`endif
        end else begin
            ready_en <= 1'b1;
            sync_q   <= sync_in;
            if (push)
                wr_ptr <= wr_ptr + (AB+1)'(1);
            if (pop)
                rd_ptr <= rd_ptr + (AB+1)'(1);
            ramp <= ramp + 10'd1;
            lfsr <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
            // Load forces phase 0 so the first align sample carries fclk=11111
            if (sync_rise) begin
                align_cnt <= ACW'(G_ALIGN_FRAMES);
                phase     <= 1'b0;
            end else begin
                phase <= ~phase;
                if (align_active)
                    align_cnt <= align_cnt - ACW'(1);
            end
            if (underflow_evt && underflow_cnt != '1)
                underflow_cnt <= underflow_cnt + 16'd1;
            s1_data  <= gen;
            s1_phase <= phase;
            s1_align <= align_active;
`ifdef ADS5296_TX_ERR_INJECT_EN
            err_q    <= err_inject;
`endif
        end
    end

    // Wire split and slip: output = ({prev, cur} >> slip)[4:0]
    always_comb begin
        logic [9:0] pair_a;
        logic [9:0] pair_b;
        cur_a  = '0;
        cur_b  = '0;
        nxt_a  = '0;
        nxt_b  = '0;
        pair_a = '0;
        pair_b = '0;
        for (int unsigned k = 0; k < G_NUM_CH; k++) begin
            cur_a[5*k +: 5] = {s1_data[10*k+9], s1_data[10*k+7], s1_data[10*k+5],
                               s1_data[10*k+3], s1_data[10*k+1]};
            cur_b[5*k +: 5] = {s1_data[10*k+8], s1_data[10*k+6], s1_data[10*k+4],
                               s1_data[10*k+2], s1_data[10*k+0]};
            pair_a = {prev_a[5*k +: 5], cur_a[5*k +: 5]} >> slip_eff;
            pair_b = {prev_b[5*k +: 5], cur_b[5*k +: 5]} >> slip_eff;
            nxt_a[5*k +: 5] = pair_a[4:0];
            nxt_b[5*k +: 5] = pair_b[4:0];
        end
    end

    // Stage 2: output register
    always_ff @(posedge sclk2_in) begin
        if (rst) begin
            prev_a    <= '0;
            prev_b    <= '0;
            dout_a    <= '0;
            dout_b    <= '0;
            fclk_word <= '0;
            aligning  <= 1'b0;
            sync_out  <= 1'b0;
        end else begin
            prev_a    <= cur_a;
            prev_b    <= cur_b;
            dout_a    <= nxt_a;
            dout_b    <= nxt_b;
            fclk_word <= s1_phase ? 5'b00000 : 5'b11111;
            aligning  <= s1_align;
            sync_out  <= aligning & ~s1_align;
        end
    end
endmodule
